// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} loader_state_t;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface imem_loader_if;
  import loader_pkg::*;

  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic          imem_we_o;
  logic [31:0]   imem_addr_o;
  logic [31:0]   imem_data_o;
  logic          start_o;
  logic          busy_o;
  logic          err_o;
  loader_state_t dbg_state;

  // A byte transfers on a rising edge where byte_valid_i and byte_ready_o are
  // both high; the source holds byte_i stable while valid is high and not ready.
  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    input  start_o, busy_o, err_o, dbg_state
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    output start_o, busy_o, err_o, dbg_state
  );
endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes into little-endian 32-bit words and keeps the XOR checksum.
module word_assembler
  import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word,
    output logic              word_done,
    output logic [CSUM_W-1:0] csum
);

    logic [1:0]  cnt;
    logic [23:0] sreg;

    // The fourth byte completes the word in the same cycle it is accepted.
    assign word      = {byte_in, sreg};
    assign word_done = en && (cnt == 2'd3);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt  <= '0;
            sreg <= '0;
            csum <= '0;
        end else if (en) begin
            cnt  <= cnt + 2'd1;
            sreg <= {byte_in, sreg[23:8]};
            csum <= csum ^ byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed byte image and writes it to
// instruction memory, releasing the CPU with start_o once it verifies.
module imem_loader
  import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    imem_loader_if.slave bus
);

    localparam int          LEN_W = HDR_BYTES * 8;
    localparam logic [31:0] CAP   = 32'(1) << ADDR_W;

    loader_state_t     state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   word_idx;
    logic              accept;
    logic              asm_en;
    logic              word_done;
    logic [31:0]       word;
    logic [CSUM_W-1:0] csum;

    assign accept   = bus.byte_valid_i && bus.byte_ready_o;
    assign asm_en   = accept && (state == DATA);
    assign len_full = {bus.byte_i, len[7:0]};

    assign bus.dbg_state = state;

    word_assembler u_asm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en        (asm_en),
        .byte_in   (bus.byte_i),
        .word      (word),
        .word_done (word_done),
        .csum      (csum)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state            <= LEN0;
            len              <= '0;
            word_idx         <= '0;
            bus.imem_we_o    <= 1'b0;
            bus.imem_addr_o  <= '0;
            bus.imem_data_o  <= '0;
            bus.byte_ready_o <= 1'b1;
            bus.busy_o       <= 1'b1;
            bus.start_o      <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.imem_we_o <= 1'b0;
            case (state)
                LEN0: if (accept) begin
                    len[7:0] <= bus.byte_i;
                    state    <= LEN1;
                end
                LEN1: if (accept) begin
                    len <= len_full;
                    // A full-capacity image is legal; one word more is rejected before any write.
                    if (32'(len_full) > CAP) begin
                        state            <= ERR;
                        bus.err_o        <= 1'b1;
                        bus.byte_ready_o <= 1'b0;
                        bus.busy_o       <= 1'b0;
                    end else if (len_full == '0) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (word_done) begin
                    bus.imem_we_o   <= 1'b1;
                    bus.imem_addr_o <= 32'({word_idx, 2'b00});
                    bus.imem_data_o <= word;
                    word_idx        <= word_idx + 1'b1;
                    if ((32'(word_idx) + 32'd1) == 32'(len)) state <= CSUM;
                end
                CSUM: if (accept) begin
                    bus.byte_ready_o <= 1'b0;
                    bus.busy_o       <= 1'b0;
                    if (bus.byte_i == csum) begin
                        state       <= DONE;
                        bus.start_o <= 1'b1;
                    end else begin
                        state     <= ERR;
                        bus.err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
